// File: rtl/accel_pkg.sv
// Shared accelerator datapath widths and serializer state type.
// Pure declarations: no latency, no backpressure.
package accel_pkg;

  localparam int ACC_WORD_W = 16;
  localparam int BEAT_W     = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  // A one-beat word still needs a 1-bit counter so ports never collapse to zero width.
  function automatic int cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/beat_counter.sv
// Modulo-BEATS beat index with clear and terminal count; one-cycle update latency.
// No handshake of its own: advances only when the parent asserts en.
module beat_counter
  import accel_pkg::*;
#(
  parameter int  BEATS = 4,
  localparam int CW    = cnt_width(BEATS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  assign tc = (cnt == LAST);

  // clr wins over en: a reload on the last beat restarts the word at beat 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/word_serializer.sv
// Unloads one N-bit word as N/W W-bit beats, LSB first; beat 0 appears the cycle after accept.
// Beats hold under out_ready=0; in_ready reopens combinationally on the last beat's handshake.
module word_serializer
  import accel_pkg::*;
#(
  parameter int  N     = ACC_WORD_W,
  parameter int  W     = BEAT_W,
  localparam int BEATS = N / W,
  localparam int CW    = cnt_width(BEATS)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last
);

  if ((W < 1) || (W > N) || ((N % W) != 0)) begin : g_bad_width
    $error("word_serializer: N must be a positive multiple of W");
  end

  ser_state_e    state_q;
  ser_state_e    state_d;
  logic [N-1:0]  shift_q;
  logic [CW-1:0] count;
  logic          cnt_tc;
  logic          accept;
  logic          beat_hs;

  assign out_valid = (state_q == SHIFT);
  assign out_data  = shift_q[W-1:0];
  assign out_last  = out_valid && (count == CW'(BEATS - 1));

  assign beat_hs  = out_valid && out_ready;
  assign in_ready = rst && ((state_q == IDLE) || (beat_hs && out_last));
  assign accept   = in_valid && in_ready;

  beat_counter #(
    .BEATS (BEATS)
  ) u_beat_counter (
    .clk (clk),
    .rst (rst),
    .en  (beat_hs),
    .clr (accept),
    .cnt (count),
    .tc  (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (beat_hs && cnt_tc && !accept) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Draining the last beat clears the register so an idle block shows a zero beat.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shift_q <= '0;
    end else if (accept) begin
      shift_q <= in_data;
    end else if (beat_hs) begin
      shift_q <= cnt_tc ? '0 : (shift_q >> W);
    end
  end

endmodule
